// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time, and
// registers instruction/currPC/pc_plus4 for the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] currPC,
    output logic [63:0] pc_plus4,
    output logic        IF_ID_flush
);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e      r_state, w_state_d;
    logic [63:0] r_pc, w_pc_d;
    logic [63:0] r_drop_addr, w_drop_addr_d;
    logic [31:0] r_instr, w_instr_d;
    logic [63:0] r_curr_pc, w_curr_pc_d;
    logic [63:0] r_pc_plus4, w_pc_plus4_d;
    logic        r_fetch_valid, w_fetch_valid_d;

    logic [63:0] w_br_pc;
    logic [63:0] w_pc_inc;

    assign w_br_pc  = {br_target[63:2], 2'b00};
    assign w_pc_inc = r_pc + 64'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_drop_addr   <= RESET_PC;
            r_instr       <= 32'd0;
            r_curr_pc     <= 64'd0;
            r_pc_plus4    <= 64'd0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_drop_addr   <= w_drop_addr_d;
            r_instr       <= w_instr_d;
            r_curr_pc     <= w_curr_pc_d;
            r_pc_plus4    <= w_pc_plus4_d;
            r_fetch_valid <= w_fetch_valid_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_drop_addr_d   = r_drop_addr;
        w_instr_d       = r_instr;
        w_curr_pc_d     = r_curr_pc;
        w_pc_plus4_d    = r_pc_plus4;
        w_fetch_valid_d = r_fetch_valid;
        unique case (r_state)
            StIdle: begin
                w_state_d = StReq;
                if (br_taken) begin
                    w_pc_d          = w_br_pc;
                    w_fetch_valid_d = 1'b0;
                end
            end
            StReq: begin
                if (br_taken) begin
                    w_pc_d          = w_br_pc;
                    w_fetch_valid_d = 1'b0;
                    // Pending request must keep its address until memory answers it.
                    if (!imem_valid) begin
                        w_drop_addr_d = r_pc;
                        w_state_d     = StDrop;
                    end
                end else if (imem_valid) begin
                    if (!stall) begin
                        w_instr_d       = imem_rdata;
                        w_curr_pc_d     = r_pc;
                        w_pc_plus4_d    = w_pc_inc;
                        w_pc_d          = w_pc_inc;
                        w_fetch_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    w_fetch_valid_d = 1'b0;
                end
            end
            StDrop: begin
                w_fetch_valid_d = 1'b0;
                if (br_taken) begin
                    w_pc_d = w_br_pc;
                end
                if (imem_valid) begin
                    w_state_d = StReq;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req    = (r_state != StIdle);
        imem_addr   = (r_state == StDrop) ? r_drop_addr : r_pc;
        instruction = r_instr;
        currPC      = r_curr_pc;
        pc_plus4    = r_pc_plus4;
        IF_ID_flush = ~r_fetch_valid;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: zero-wait and multi-cycle memory, stalls,
// branch redirects (including DROP), PC wrap and asynchronous reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instruction;
    logic [63:0] currPC;
    logic [63:0] pc_plus4;
    logic        IF_ID_flush;

    int checks = 0;
    int errors = 0;
    bit auto_mem = 1'b1;

    if_fetch_stage #(.RESET_PC(64'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .currPC     (currPC),
        .pc_plus4   (pc_plus4),
        .IF_ID_flush(IF_ID_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [63:0] a);
        return 32'hF840_5087 + a[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait memory: answer whatever is currently requested.
    task automatic mem_now();
        imem_valid = imem_req;
        imem_rdata = instr_at(imem_addr);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_mem) mem_now();
    endtask

    initial begin
        #2 reset = 1'b0;
        cycle();
        cycle();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_flush", 64'(IF_ID_flush), 64'd1);
        check("rst_instr", 64'(instruction), 64'd0);
        check("rst_curr", currPC, 64'd0);
        check("rst_pc4", pc_plus4, 64'd0);

        // Zero-wait streaming
        reset = 1'b1;
        cycle();
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, 64'd0);
        check("first_flush", 64'(IF_ID_flush), 64'd1);
        cycle();
        check("f0_instr", 64'(instruction), 64'hF840_5087);
        check("f0_curr", currPC, 64'd0);
        check("f0_pc4", pc_plus4, 64'd4);
        check("f0_flush", 64'(IF_ID_flush), 64'd0);
        check("f0_addr", imem_addr, 64'd4);
        cycle();
        check("f1_curr", currPC, 64'd4);
        check("f1_addr", imem_addr, 64'd8);

        // Stall at pc=8 for two cycles with data presented
        stall = 1'b1;
        cycle();
        check("st1_addr", imem_addr, 64'd8);
        check("st1_curr", currPC, 64'd4);
        check("st1_flush", 64'(IF_ID_flush), 64'd0);
        cycle();
        check("st2_addr", imem_addr, 64'd8);
        check("st2_curr", currPC, 64'd4);
        stall = 1'b0;
        cycle();
        check("st_rel_curr", currPC, 64'd8);
        check("st_rel_instr", 64'(instruction), 64'(instr_at(64'd8)));
        check("st_rel_addr", imem_addr, 64'd12);

        // Asynchronous reset mid-run, then 3-cycle-latency memory
        reset = 1'b0;
        #1;
        check("async_req", 64'(imem_req), 64'd0);
        check("async_flush", 64'(IF_ID_flush), 64'd1);
        check("async_addr", imem_addr, 64'd0);
        auto_mem = 1'b0;
        imem_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("lat1_req", 64'(imem_req), 64'd1);
        check("lat1_addr", imem_addr, 64'd0);
        cycle();
        check("lat2_addr", imem_addr, 64'd0);
        check("lat2_flush", 64'(IF_ID_flush), 64'd1);
        cycle();
        check("lat3_addr", imem_addr, 64'd0);
        check("lat3_req", 64'(imem_req), 64'd1);
        check("lat3_flush", 64'(IF_ID_flush), 64'd1);
        imem_valid = 1'b1;
        imem_rdata = 32'hF840_5087;
        cycle();
        check("lat_curr", currPC, 64'd0);
        check("lat_flush", 64'(IF_ID_flush), 64'd0);
        check("lat_addr", imem_addr, 64'd4);
        imem_valid = 1'b0;
        cycle();
        check("bubble_flush", 64'(IF_ID_flush), 64'd1);
        check("bubble_addr", imem_addr, 64'd4);
        mem_now();
        cycle();
        check("r4_curr", currPC, 64'd4);
        mem_now();
        cycle();
        mem_now();
        cycle();
        check("r12_curr", currPC, 64'd12);
        check("r16_addr", imem_addr, 64'd16);

        // Branch while request to 16 is pending -> DROP
        imem_valid = 1'b0;
        br_taken = 1'b1;
        br_target = 64'd203;
        cycle();
        br_taken = 1'b0;
        check("drop_addr", imem_addr, 64'd16);
        check("drop_flush", 64'(IF_ID_flush), 64'd1);
        cycle();
        check("drop2_addr", imem_addr, 64'd16);
        imem_valid = 1'b1;
        imem_rdata = instr_at(64'd16);
        cycle();
        check("drop_done_addr", imem_addr, 64'd200);
        check("drop_done_flush", 64'(IF_ID_flush), 64'd1);
        check("drop_done_curr", currPC, 64'd12);
        auto_mem = 1'b1;
        mem_now();
        cycle();
        check("br_curr", currPC, 64'd200);
        check("br_pc4", pc_plus4, 64'd204);
        check("br_flush", 64'(IF_ID_flush), 64'd0);

        // Branch and stall together with valid data: branch wins
        br_taken = 1'b1;
        stall = 1'b1;
        br_target = 64'h1000;
        cycle();
        br_taken = 1'b0;
        stall = 1'b0;
        check("bs_addr", imem_addr, 64'h1000);
        check("bs_flush", 64'(IF_ID_flush), 64'd1);
        check("bs_curr", currPC, 64'd200);
        cycle();
        check("bs_next_curr", currPC, 64'h1000);
        check("bs_next_flush", 64'(IF_ID_flush), 64'd0);

        // PC wrap at top of address space
        br_taken = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle();
        br_taken = 1'b0;
        check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        check("wrap_curr", currPC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc4", pc_plus4, 64'd0);
        check("wrap_next", imem_addr, 64'd0);
        check("wrap_instr", 64'(instruction), 64'h0000_0000_F840_5083);

        // Asynchronous reset without a clock edge
        reset = 1'b0;
        #1;
        check("async2_req", 64'(imem_req), 64'd0);
        check("async2_flush", 64'(IF_ID_flush), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
